// File: rtl/sc_ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding,
// next-PC select codes and the reset-time nop instruction.
package sc_ifu_pkg;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BRA  = 2'b01;
   localparam logic [1:0] PC_JALR = 2'b10;
   localparam logic [1:0] PC_JAL  = 2'b11;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/sc_npc_mux.sv
// Next-PC selection and word-alignment check for the fetch unit.
module sc_npc_mux
   import sc_ifu_pkg::*;
(
   input  logic [1:0]  pcsource,
   input  logic [31:0] pc4,
   input  logic [31:0] bra_target,
   input  logic [31:0] jalr_target,
   input  logic [31:0] jal_target,
   output logic [31:0] next_pc,
   output logic        next_pc_ok
);

   // select the next fetch address; jalr drops bit 0 before the alignment test
   always_comb begin
      next_pc = pc4;
      case (pcsource)
         PC_SEQ:  next_pc = pc4;
         PC_BRA:  next_pc = bra_target;
         PC_JALR: next_pc = {jalr_target[31:1], 1'b0};
         PC_JAL:  next_pc = jal_target;
         default: next_pc = pc4;
      endcase
      next_pc_ok = is_word_aligned(next_pc);
   end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: fetches one word per instruction, holds it
// until the execute stage acknowledges it, then steers to the next PC.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | request issued at pc; zero-wait response captured here
// WAIT     | request outstanding, address held until imem_rdy
// VALID    | inst/pc presented, waiting for inst_ack
// HALT     | misaligned next PC seen; parked until reset
module sc_ifu
   import sc_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bra_target,
   input  logic [31:0] jalr_target,
   input  logic [31:0] jal_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        inst_valid,
   input  logic        inst_ack,
   output logic        misalign
);

   logic [1:0]  state;
   logic [31:0] next_pc;
   logic        next_pc_ok;

   sc_npc_mux u_npc_mux (
      .pcsource    (pcsource),
      .pc4         (pc4),
      .bra_target  (bra_target),
      .jalr_target (jalr_target),
      .jal_target  (jal_target),
      .next_pc     (next_pc),
      .next_pc_ok  (next_pc_ok)
   );

   // outputs decoded from state; the request is gated by resetn so it
   // drops the instant reset asserts even though reset parks us in FETCH
   always_comb begin
      pc4        = pc + 32'd4;
      imem_addr  = pc;
      imem_req   = resetn && ((state == ST_FETCH) || (state == ST_WAIT));
      inst_valid = (state == ST_VALID);
   end

   // fetch sequencing, instruction capture and PC update
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_FETCH;
         pc       <= RESET_PC;
         inst     <= NOP;
         misalign <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (imem_rdy) begin
                  inst  <= imem_rdata;
                  state <= ST_VALID;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rdy) begin
                  inst  <= imem_rdata;
                  state <= ST_VALID;
               end
            end
            ST_VALID: begin
               if (inst_ack) begin
                  if (next_pc_ok) begin
                     pc    <= next_pc;
                     state <= ST_FETCH;
                  end else begin
                     misalign <= 1'b1;
                     state    <= ST_HALT;
                  end
               end
            end
            default: begin
               misalign <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_ifu.sv
// Bench for sc_ifu: directed ack sequences, a small memory responder with
// programmable latency, and a scoreboard of expected {pc, inst} pairs.
module tb_sc_ifu;
   import sc_ifu_pkg::*;

   localparam logic [31:0] DKEY = 32'h0050_0093;

   logic        clock;
   logic        resetn;
   logic [1:0]  pcsource;
   logic [31:0] bra_target, jalr_target, jal_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;
   logic [31:0] inst, pc, pc4;
   logic        inst_valid;
   logic        inst_ack;
   logic        misalign;

   int compared = 0;
   int failed   = 0;
   int mem_delay = 0;
   int wait_cnt;
   int waited;
   logic prev_valid = 1'b0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t sb_q[$];

   sc_ifu #(.RESET_PC(32'h0000_0000)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .pcsource    (pcsource),
      .bra_target  (bra_target),
      .jalr_target (jalr_target),
      .jal_target  (jal_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .pc          (pc),
      .pc4         (pc4),
      .inst_valid  (inst_valid),
      .inst_ack    (inst_ack),
      .misalign    (misalign)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // memory: answers after mem_delay full cycles of a held request
   assign imem_rdy   = imem_req && (wait_cnt >= mem_delay);
   assign imem_rdata = imem_addr ^ DKEY;

   always @(posedge clock or negedge resetn) begin
      if (!resetn)
         wait_cnt <= 0;
      else if (imem_req && !imem_rdy)
         wait_cnt <= wait_cnt + 1;
      else
         wait_cnt <= 0;
   end

   // monitor: each newly presented instruction is matched against the queue
   always @(negedge clock) begin
      if (resetn && inst_valid && !prev_valid) begin
         compared++;
         if (sb_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected: pc=%h inst=%h presented, none expected", pc, inst);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (pc !== e.pc || inst !== e.inst) begin
               failed++;
               $display("FAIL sb_fetch: got pc=%h inst=%h, expected pc=%h inst=%h",
                        pc, inst, e.pc, e.inst);
            end
         end
      end
      prev_valid = resetn ? inst_valid : 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
      exp_t e;
      e.pc = p;
      e.inst = i;
      sb_q.push_back(e);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         n++;
         if (inst_valid) return;
      end
      compared++;
      failed++;
      $display("FAIL wait_valid: inst_valid got 0 after 50 cycles, expected 1");
   endtask

   task automatic do_ack(input logic [1:0] src, input logic [31:0] b,
                         input logic [31:0] jr, input logic [31:0] j);
      pcsource    = src;
      bra_target  = b;
      jalr_target = jr;
      jal_target  = j;
      inst_ack    = 1'b1;
      @(posedge clock);
      #1;
      inst_ack = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      pcsource = PC_SEQ;
      bra_target = '0;
      jalr_target = '0;
      jal_target = '0;
      inst_ack = 1'b0;

      // reset state
      #12;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_inst", inst, NOP);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);

      push_exp(32'h0, 32'h0050_0093);
      @(negedge clock);
      resetn = 1'b1;
      #1;
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0);

      // zero-wait sequential fetch, one instruction per two cycles
      wait_valid(waited);
      push_exp(32'h4, 32'h0050_0097);
      do_ack(PC_SEQ, 0, 0, 0);
      wait_valid(waited);
      check("seq_gap_4", waited, 32'd2);
      push_exp(32'h8, 32'h0050_009B);
      do_ack(PC_SEQ, 0, 0, 0);
      wait_valid(waited);
      check("seq_gap_8", waited, 32'd2);

      // three wait states
      mem_delay = 3;
      push_exp(32'hC, 32'h0050_009F);
      do_ack(PC_SEQ, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("wait_req", {31'd0, imem_req}, 32'd1);
         check("wait_addr", imem_addr, 32'hC);
         check("wait_novalid", {31'd0, inst_valid}, 32'd0);
      end
      @(negedge clock);
      check("wait_valid_rise", {31'd0, inst_valid}, 32'd1);
      mem_delay = 0;

      // jal to 0x100, branch to 0x0F0, jalr with bit 0 cleared
      push_exp(32'h100, 32'h0050_0193);
      do_ack(PC_JAL, 32'h0, 32'h0, 32'h100);
      wait_valid(waited);
      push_exp(32'hF0, 32'h0050_0063);
      do_ack(PC_BRA, 32'hF0, 32'h0, 32'h0);
      @(negedge clock);
      check("bra_addr", imem_addr, 32'hF0);
      wait_valid(waited);
      push_exp(32'h204, 32'h0050_0297);
      do_ack(PC_JALR, 32'h0, 32'h205, 32'h0);

      // hold without ack while selects toggle
      wait_valid(waited);
      for (int k = 0; k < 5; k++) begin
         pcsource    = 2'(k);
         bra_target  = 32'h1000 + 32'(k);
         jalr_target = 32'h2001 + 32'(k);
         jal_target  = 32'h3002 + 32'(k);
         @(negedge clock);
         check("hold_pc", pc, 32'h204);
         check("hold_inst", inst, 32'h0050_0297);
         check("hold_req", {31'd0, imem_req}, 32'd0);
         check("hold_valid", {31'd0, inst_valid}, 32'd1);
      end

      // misaligned jalr target 0x203 -> 0x202
      do_ack(PC_JALR, 32'h0, 32'h203, 32'h0);
      inst_ack = 1'b1;
      pcsource = PC_SEQ;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("halt_misalign", {31'd0, misalign}, 32'd1);
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_valid", {31'd0, inst_valid}, 32'd0);
         check("halt_pc", pc, 32'h204);
      end
      inst_ack = 1'b0;

      // reset out of HALT clears misalign
      #2;
      resetn = 1'b0;
      #1;
      check("halt_rst_misalign", {31'd0, misalign}, 32'd0);
      check("halt_rst_pc", pc, 32'h0);
      sb_q.delete();
      push_exp(32'h0, 32'h0050_0093);
      @(negedge clock);
      resetn = 1'b1;
      wait_valid(waited);

      // reset asserted in the middle of a WAIT at 0x40
      mem_delay = 5;
      do_ack(PC_JAL, 32'h0, 32'h0, 32'h40);
      @(negedge clock);
      @(negedge clock);
      check("midwait_addr", imem_addr, 32'h40);
      check("midwait_req", {31'd0, imem_req}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_pc", pc, 32'h0);
      check("midrst_inst", inst, NOP);
      check("midrst_misalign", {31'd0, misalign}, 32'd0);
      mem_delay = 2;
      sb_q.delete();
      push_exp(32'h0, 32'h0050_0093);
      @(negedge clock);
      resetn = 1'b1;
      #1;
      check("refetch_req", {31'd0, imem_req}, 32'd1);
      check("refetch_addr", imem_addr, 32'h0);
      wait_valid(waited);
      mem_delay = 0;

      // wrap from the top of the address space
      push_exp(32'hFFFF_FFFC, 32'hFFAF_FF6F);
      do_ack(PC_JAL, 32'h0, 32'h0, 32'hFFFF_FFFC);
      wait_valid(waited);
      check("wrap_pc4", pc4, 32'h0);
      push_exp(32'h0, 32'h0050_0093);
      do_ack(PC_SEQ, 0, 0, 0);
      wait_valid(waited);
      check("wrap_pc", pc, 32'h0);
      check("wrap_misalign", {31'd0, misalign}, 32'd0);

      @(negedge clock);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
